// File: rtl/vpu_timing_pkg.sv
// Shared timing types and default 640x480@60 constants for the video timing blocks.
package vpu_timing_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } req_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 4;

    localparam logic [7:0] OVERRUN_MAX = 8'hFF;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Control, handshake and timing outputs of the VGA timing generator.
interface vga_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           en;
    logic           frame_ack;
    logic           pix_en;
    logic           hsync;
    logic           vsync;
    logic           blank;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           line_start;
    logic           frame_start;
    logic           frame_req;
    logic [7:0]     overrun;

    modport master (
        input  en, frame_ack,
        output pix_en, hsync, vsync, blank, x, y,
               line_start, frame_start, frame_req, overrun
    );

    modport slave (
        output en, frame_ack,
        input  pix_en, hsync, vsync, blank, x, y,
               line_start, frame_start, frame_req, overrun
    );
endinterface

// File: rtl/timing_axis_cnt.sv
// Wrapping 0..TOTAL-1 counter used for both the pixel (x) and line (y) axes.
module timing_axis_cnt #(
    parameter int TOTAL = 800,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_reg;

    assign wrap = inc && (cnt_reg == LAST);
    assign cnt  = cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= wrap ? '0 : cnt_reg + W'(1);
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blank generator with pixel-rate divider and a vertical-blank refresh request.
module vga_timing_gen
    import vpu_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W     = $clog2(H_TOTAL);
    localparam int Y_W     = $clog2(V_TOTAL);

    localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_FIRST = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_FIRST = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [Y_W-1:0] Y_LAST_ACT = Y_W'(V_ACTIVE - 1);

    logic           pix_en;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           x_wrap;
    logic           y_wrap;
    logic           fe;
    logic           hs_on;
    logic           vs_on;

    req_state_t state_reg, state_next;
    logic [7:0] overrun_reg, overrun_next;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign pix_en = vif.en;
        end else begin : g_div
            localparam int DIV_W = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
            logic [DIV_W-1:0] div_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    div_reg <= '0;
                end else if (vif.en) begin
                    div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
                end
            end

            assign pix_en = vif.en && (div_reg == DIV_LAST);
        end
    endgenerate

    timing_axis_cnt #(.TOTAL(H_TOTAL), .W(X_W)) u_x_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pix_en),
        .cnt   (x_cnt),
        .wrap  (x_wrap)
    );

    timing_axis_cnt #(.TOTAL(V_TOTAL), .W(Y_W)) u_y_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (x_wrap),
        .cnt   (y_cnt),
        .wrap  (y_wrap)
    );

    // Decoded straight from the live counters so syncs line up with x/y.
    assign hs_on = (x_cnt >= HS_FIRST) && (x_cnt <= HS_LAST);
    assign vs_on = (y_cnt >= VS_FIRST) && (y_cnt <= VS_LAST);

    // Frame event: last pixel of the last active line, i.e. entry into vblank.
    assign fe = x_wrap && (y_cnt == Y_LAST_ACT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            overrun_reg <= '0;
        end else begin
            state_reg   <= state_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        overrun_next = overrun_reg;
        if (vif.en) begin
            case (state_reg)
                IDLE: begin
                    if (fe) state_next = PEND;
                end
                PEND: begin
                    // A new frame while still pending: an ack in the same cycle only cancels the miss.
                    if (fe) begin
                        if (!vif.frame_ack && (overrun_reg != OVERRUN_MAX))
                            overrun_next = overrun_reg + 8'd1;
                    end else if (vif.frame_ack) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign vif.pix_en      = pix_en;
    assign vif.hsync       = hs_on ? SYNC_POL : ~SYNC_POL;
    assign vif.vsync       = vs_on ? SYNC_POL : ~SYNC_POL;
    assign vif.blank       = (x_cnt >= X_ACT) || (y_cnt >= Y_ACT);
    assign vif.x           = x_cnt;
    assign vif.y           = y_cnt;
    assign vif.line_start  = pix_en && (x_cnt == '0);
    assign vif.frame_start = pix_en && (x_cnt == '0) && (y_cnt == '0);
    assign vif.frame_req   = (state_reg == PEND);
    assign vif.overrun     = overrun_reg;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small 16x8 frame with a closed-form timing model, plus a default-size instance.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vpu_timing_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_n_d;

    vga_timing_gen_if #(.X_W(4), .Y_W(3))   vif ();
    vga_timing_gen_if #(.X_W(10), .Y_W(10)) vif_d ();

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .SYNC_POL(1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vif)
    );

    vga_timing_gen dut_d (
        .clk   (clk),
        .rst_n (rst_n_d),
        .vif   (vif_d)
    );

    int tests = 0;
    int fails = 0;
    int n_en  = 0;
    bit def_done = 1'b0;

    typedef struct {
        string name;
        int    exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int         x;
        int         y;
        logic [2:0] hvb;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic sb_push(input string name, input int exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input int act);
        sb_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check(e.name, act, e.exp);
        end
    endtask

    // Closed form: n enabled edges since reset -> divider n%2, pixel n/2.
    function automatic logic [12:0] model_vec(input int n, input logic en);
        int p, mx, my;
        logic pe, hs, vs, bl, ls, fs;
        p  = n / 2;
        mx = p % 16;
        my = (p / 16) % 8;
        pe = en && ((n % 2) == 1);
        hs = !(mx >= 10 && mx <= 12);
        vs = !(my >= 5 && my <= 6);
        bl = (mx >= 8) || (my >= 4);
        ls = pe && (mx == 0);
        fs = ls && (my == 0);
        return {pe, hs, vs, bl, ls, fs, 4'(mx), 3'(my)};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {vif.pix_en, vif.hsync, vif.vsync, vif.blank,
                vif.line_start, vif.frame_start, vif.x, vif.y};
    endfunction

    task automatic tick();
        logic r, e;
        r = rst_n;
        e = vif.en;
        @(posedge clk);
        #1;
        if (!r) n_en = 0;
        else if (e) n_en++;
    endtask

    task automatic run_model(input int cycles, input string tag);
        int nn;
        for (int i = 0; i < cycles; i++) begin
            nn = !rst_n ? 0 : (vif.en ? n_en + 1 : n_en);
            sb_push(tag, int'(model_vec(nn, vif.en)));
            tick();
            sb_pop(int'(dut_vec()));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_fe(input string tag);
        int k;
        k = 0;
        while (!(vif.pix_en && vif.x == 4'd15 && vif.y == 3'd3) && k < 600) begin
            tick();
            k++;
        end
        check({tag, "_fe_seen"}, int'(k < 600), 1);
    endtask

    initial begin
        int k, c;
        rst_n = 1'b0;
        vif.en = 1'b0;
        vif.frame_ack = 1'b0;
        tick();
        tick();
        check("rst_outputs", int'({vif.pix_en, vif.hsync, vif.vsync, vif.blank,
                                   vif.line_start, vif.frame_start, vif.frame_req}), 'b0110000);
        check("rst_xy", int'({vif.x, vif.y}), 0);
        check("rst_overrun", int'(vif.overrun), 0);
        $display("[TB] reset state checked");

        rst_n = 1'b1;
        vif.en = 1'b1;
        run_model(256, "freerun");
        $display("[TB] free run frame checked against model");

        k = 0;
        while (!vif.frame_start && k < 300) begin tick(); k++; end
        c = 0;
        do begin tick(); c++; end while (!vif.frame_start && c < 300);
        check("frame_start_period", c, 256);
        $display("[TB] frame_start period %0d clks", c);

        vecs[0]  = '{0, 0, 3'b110};  vecs[1]  = '{7, 3, 3'b110};
        vecs[2]  = '{8, 0, 3'b111};  vecs[3]  = '{10, 0, 3'b011};
        vecs[4]  = '{12, 0, 3'b011}; vecs[5]  = '{13, 0, 3'b111};
        vecs[6]  = '{15, 3, 3'b111}; vecs[7]  = '{0, 4, 3'b111};
        vecs[8]  = '{7, 5, 3'b101};  vecs[9]  = '{9, 6, 3'b101};
        vecs[10] = '{11, 6, 3'b001}; vecs[11] = '{3, 7, 3'b111};
        for (int v = 0; v < 12; v++) begin
            sb_push($sformatf("decode_x%0d_y%0d", vecs[v].x, vecs[v].y), int'(vecs[v].hvb));
            k = 0;
            while (!(int'(vif.x) == vecs[v].x && int'(vif.y) == vecs[v].y) && k < 600) begin
                tick();
                k++;
            end
            sb_pop(int'({vif.hsync, vif.vsync, vif.blank}));
            $display("[TB] decode x=%0d y=%0d hvb=%b", vecs[v].x, vecs[v].y, {vif.hsync, vif.vsync, vif.blank});
        end

        do_reset();
        vif.frame_ack = 1'b1;
        run_model(4, "ack_idle");
        vif.frame_ack = 1'b0;
        check("ack_idle_req", int'(vif.frame_req), 0);
        wait_fe("hs");
        check("hs_req_before_fe", int'(vif.frame_req), 0);
        tick();
        check("hs_req_after_fe", int'(vif.frame_req), 1);
        repeat (4) tick();
        check("hs_req_held", int'(vif.frame_req), 1);
        vif.frame_ack = 1'b1;
        tick();
        vif.frame_ack = 1'b0;
        check("hs_req_cleared", int'(vif.frame_req), 0);
        check("hs_overrun", int'(vif.overrun), 0);
        $display("[TB] handshake req=%0d overrun=%0d", vif.frame_req, vif.overrun);

        for (int f = 1; f <= 3; f++) begin
            wait_fe("ovr");
            tick();
        end
        check("ovr3_req", int'(vif.frame_req), 1);
        check("ovr3_cnt", int'(vif.overrun), 2);
        $display("[TB] overrun after 3 frames = %0d", vif.overrun);
        for (int f = 4; f <= 300; f++) begin
            wait_fe("ovr");
            tick();
            if (f == 257) check("ovr257_cnt", int'(vif.overrun), 255);
        end
        check("ovr300_req", int'(vif.frame_req), 1);
        check("ovr300_cnt", int'(vif.overrun), 255);
        $display("[TB] overrun after 300 frames = %0d", vif.overrun);

        do_reset();
        wait_fe("co1");
        tick();
        check("co_pend", int'(vif.frame_req), 1);
        wait_fe("co2");
        vif.frame_ack = 1'b1;
        tick();
        vif.frame_ack = 1'b0;
        check("co_req", int'(vif.frame_req), 1);
        check("co_overrun", int'(vif.overrun), 0);
        tick();
        check("co_req_next", int'(vif.frame_req), 1);
        vif.frame_ack = 1'b1;
        tick();
        vif.frame_ack = 1'b0;
        check("co_req_cleared", int'(vif.frame_req), 0);
        $display("[TB] coincident ack/fe overrun=%0d", vif.overrun);

        do_reset();
        run_model(76, "to_x6_y2");
        check("en_start_xy", int'({vif.x, vif.y}), int'({4'd6, 3'd2}));
        vif.en = 1'b0;
        run_model(20, "en_low");
        check("en_low_xy", int'({vif.x, vif.y}), int'({4'd6, 3'd2}));
        check("en_low_pix", int'(vif.pix_en), 0);
        check("en_low_req", int'(vif.frame_req), 0);
        vif.en = 1'b1;
        run_model(30, "en_resume");
        $display("[TB] enable hold checked");

        wait_fe("rp1");
        tick();
        wait_fe("rp2");
        tick();
        check("rp_pend", int'(vif.frame_req), 1);
        check("rp_overrun", int'(vif.overrun), 1);
        rst_n = 1'b0;
        tick();
        check("rp_xy", int'({vif.x, vif.y}), 0);
        check("rp_req", int'(vif.frame_req), 0);
        check("rp_overrun_clr", int'(vif.overrun), 0);
        check("rp_syncs", int'({vif.hsync, vif.vsync}), 3);
        rst_n = 1'b1;
        run_model(10, "post_rst");
        check("rp_req_lost", int'(vif.frame_req), 0);
        $display("[TB] reset in PEND checked");

        k = 0;
        while (!def_done && k < 10000) begin tick(); k++; end
        check("default_done", int'(def_done), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int k, c, hs_min, hs_max;
        rst_n_d = 1'b0;
        vif_d.en = 1'b0;
        vif_d.frame_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("d_rst_syncs", int'({vif_d.hsync, vif_d.vsync}), 3);
        rst_n_d = 1'b1;
        vif_d.en = 1'b1;
        hs_min = 9999;
        hs_max = -1;
        for (k = 0; k < 3200; k++) begin
            if (vif_d.hsync == 1'b0) begin
                if (int'(vif_d.x) < hs_min) hs_min = int'(vif_d.x);
                if (int'(vif_d.x) > hs_max) hs_max = int'(vif_d.x);
            end
            @(posedge clk);
            #1;
        end
        check("d_hsync_first", hs_min, 656);
        check("d_hsync_last", hs_max, 751);
        k = 0;
        while (!vif_d.line_start && k < 4000) begin @(posedge clk); #1; k++; end
        c = 0;
        do begin @(posedge clk); #1; c++; end while (!vif_d.line_start && c < 4000);
        check("d_line_period", c, 3200);
        check("d_fe_spacing", c * dut_d.V_TOTAL, 1680000);
        $display("[TB] default: hsync low x=%0d..%0d, line %0d clks, fe spacing %0d clks",
                 hs_min, hs_max, c, c * dut_d.V_TOTAL);
        def_done = 1'b1;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP=16, H_SYNC=96, H_BP=48, which are the horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameters V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33, which are the vertical equivalents in lines.
REQ-004 SHALL have parameter CLK_DIV, default 4, giving clk cycles per pixel (CLK_DIV>=1).
REQ-005 SHALL have parameter SYNC_POL, default 0, the active level of hsync/vsync.
REQ-006 SHALL derive H_TOTAL and V_TOTAL as the sums of their four parameters, and X_W=$clog2(H_TOTAL) and Y_W=$clog2(V_TOTAL).
REQ-007 SHALL have ports as follows; one clock; reset is synchronous and active-low:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  timing run enable
- frame_ack  in  1  consumer accepts frame_req
- pix_en  out  1  one-clk pixel strobe
- hsync, vsync  out  1  syncs at SYNC_POL
- blank  out  1  outside active area
- x  out  X_W  horizontal count
- y  out  Y_W  vertical count
- line_start  out  1  pix_en with x==0
- frame_start  out  1  pix_en with x==0, y==0
- frame_req  out  1  vertical-blank refresh request
- overrun  out  8  missed-ack counter

Function
REQ-008 SHALL run a divider 0..CLK_DIV-1 while en=1, with pix_en=1 exactly when the divider equals CLK_DIV-1 and en=1; with CLK_DIV=1, pix_en SHALL equal en.
REQ-009 SHALL advance x on pix_en and wrap H_TOTAL-1 to 0; y SHALL advance on that wrap and wrap V_TOTAL-1 to 0.
REQ-010 SHALL freeze divider, x, y and the request FSM while en=0, with all outputs holding and pix_en=0.
REQ-011 SHALL decode hsync, vsync and blank combinationally from the current x, y, with zero latency.
REQ-012 SHALL assert hsync=SYNC_POL iff H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1; vsync SHALL follow the same rule on y.
REQ-013 SHALL set blank=1 iff x>=H_ACTIVE or y>=V_ACTIVE.
REQ-014 SHALL define the frame event (FE) as pix_en with x==H_TOTAL-1 and y==V_ACTIVE-1, i.e. the entry into vertical blank.
REQ-015 SHALL implement the request FSM with states IDLE and PEND, where frame_req=1 iff the state is PEND.
REQ-016 SHALL take the FSM transition IDLE->PEND on FE.
REQ-017 SHALL take the FSM transition PEND->IDLE when frame_ack=1 and no FE occurs in the same cycle.
REQ-018 SHALL stay in PEND when FE and frame_ack coincide, without incrementing overrun.
REQ-019 SHALL, on FE while in PEND with frame_ack=0, stay in PEND and increment overrun, saturating at 255.
REQ-020 SHALL ignore frame_ack while in IDLE.

Reset
REQ-021 SHALL, on a clk edge with rst_n=0, set divider, x and y to 0, the state to IDLE and overrun to 0, regardless of the current state.
REQ-022 SHALL therefore present, during and immediately after reset: pix_en=0, hsync=vsync=~SYNC_POL, blank=0, frame_req=0, line_start=0, frame_start=0.
REQ-023 SHALL, when reset is applied mid-frame or while in PEND, drop frame_req on the next edge and lose the request without counting it.

Structure
REQ-024 SHALL place the req_state_t enum (IDLE, PEND) and the default 640x480@60 timing constants in a shared package vpu_timing_pkg.
REQ-025 SHALL implement the wrap counter as one sub-module, timing_axis_cnt (parameters TOTAL and W; ports inc, wrap), instantiated for x and for y.

Verification
Directed scenarios use a small configuration: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), CLK_DIV=2, SYNC_POL=0, giving a 256-clk frame.
REQ-026 SHALL check free run with en=1: pix_en every 2nd clk; hsync=0 exactly for x=10..12; vsync=0 for y=5..6; blank=1 for x>=8 or y>=4; frame_start every 256 clks.
REQ-027 SHALL check the handshake: after FE (x=15, y=3) frame_req=1 from the next edge; pulsing frame_ack for one clk 5 clks later gives frame_req=0 on the following edge, with overrun=0.
REQ-028 SHALL check overrun: holding frame_ack=0 for 3 frames keeps frame_req=1 with overrun=2; with frame_ack=0 held further, overrun stays at 255 after 300 frames.
REQ-029 SHALL check a coincident event: frame_ack=1 in the FE cycle while in PEND leaves frame_req=1 and overrun unchanged.
REQ-030 SHALL check en and reset: en=0 for 20 clks at x=6, y=2 holds x, y and outputs and gives pix_en=0; rst_n=0 for one clk while in PEND gives x=y=0, frame_req=0, overrun=0 and hsync=vsync=1.
REQ-031 SHALL check defaults: with the default parameters, FE spacing is 1,680,000 clks and the hsync low window is x=656..751.
